// File: rtl/adc_pkg.sv
// adc_pkg: shared parameter defaults and window state encoding for adc_moving_avg.
package adc_pkg;
    localparam int ADC_DATA_W = 12;
    localparam int ADC_LOG2_DEPTH = 3;
    typedef enum logic [1:0] {EMPTY, FILL, FULL} avg_state_t;
endpackage

// File: rtl/adc_moving_avg_if.sv
// adc_moving_avg_if: sample input, average handshake and status signals of adc_moving_avg.
// peak_out exists only when ADC_AVG_PEAK_EN is defined.
interface adc_moving_avg_if
    import adc_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W,
    parameter int LOG2_DEPTH = ADC_LOG2_DEPTH
);
    logic [DATA_W-1:0] sample_in;
    logic sample_valid;
    logic clear;
    logic [DATA_W-1:0] avg_out;
    logic avg_valid;
    logic avg_ready;
    logic [LOG2_DEPTH:0] fill_count;
    logic overrun;
`ifdef ADC_AVG_PEAK_EN
    logic [DATA_W-1:0] peak_out;
    modport master (
        output sample_in, sample_valid, clear, avg_ready,
        input avg_out, avg_valid, fill_count, overrun, peak_out
    );
    modport slave (
        input sample_in, sample_valid, clear, avg_ready,
        output avg_out, avg_valid, fill_count, overrun, peak_out
    );
`else
    modport master (
        output sample_in, sample_valid, clear, avg_ready,
        input avg_out, avg_valid, fill_count, overrun
    );
    modport slave (
        input sample_in, sample_valid, clear, avg_ready,
        output avg_out, avg_valid, fill_count, overrun
    );
`endif
endinterface

// File: rtl/adc_avg_ring.sv
// adc_avg_ring: circular sample store; the oldest sample sits in the slot the next write overwrites.
module adc_avg_ring #(
    parameter int DATA_W = 12,
    parameter int LOG2_DEPTH = 3
) (
    input  logic SCLK,
    input  logic reset,
    input  logic clear,
    input  logic we,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] oldest
);
    logic [DATA_W-1:0] mem [2**LOG2_DEPTH];
    logic [LOG2_DEPTH-1:0] ptr;
    always_ff @(posedge SCLK or negedge reset)
        if (!reset) ptr <= '0;
        else if (clear) ptr <= '0;
        else if (we) ptr <= ptr + 1'b1;
    always_ff @(posedge SCLK)
        if (we) mem[ptr] <= din;
    assign oldest = mem[ptr];
endmodule

// File: rtl/adc_moving_avg.sv
// adc_moving_avg: running average over a 2^LOG2_DEPTH sample window with valid/ready output.
// Define ADC_AVG_PEAK_EN to add peak_out, the largest sample accepted since reset/clear.
module adc_moving_avg
    import adc_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W,
    parameter int LOG2_DEPTH = ADC_LOG2_DEPTH
) (
    input logic SCLK,
    input logic reset,
    adc_moving_avg_if.slave bus
);
    localparam int SUM_W = DATA_W + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] DEPTH = {1'b1, {LOG2_DEPTH{1'b0}}};
    avg_state_t state, state_nxt;
    logic [SUM_W-1:0] sum, sum_nxt;
    logic [DATA_W-1:0] oldest;
    logic accept, load;
    assign accept = bus.sample_valid && !bus.clear;
    assign load = accept && state_nxt == FULL;
    adc_avg_ring #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH)) u_ring (
        .SCLK(SCLK),
        .reset(reset),
        .clear(bus.clear),
        .we(accept),
        .din(bus.sample_in),
        .oldest(oldest)
    );
    always_ff @(posedge SCLK or negedge reset)
        if (!reset) state <= EMPTY;
        else state <= state_nxt;
    // Once full, the sample leaving the window is subtracted, so the sum never exceeds DEPTH*max.
    always_comb begin
        state_nxt = state;
        sum_nxt = sum + SUM_W'(bus.sample_in) - (state == FULL ? SUM_W'(oldest) : '0);
        if (bus.clear) state_nxt = EMPTY;
        else if (bus.sample_valid)
            state_nxt = (state == FULL || bus.fill_count == DEPTH - 1'b1) ? FULL : FILL;
    end
    always_ff @(posedge SCLK or negedge reset)
        if (!reset) begin
            sum <= '0;
            bus.fill_count <= '0;
            bus.avg_out <= '0;
            bus.avg_valid <= 1'b0;
            bus.overrun <= 1'b0;
        end else if (bus.clear) begin
            sum <= '0;
            bus.fill_count <= '0;
            bus.avg_out <= '0;
            bus.avg_valid <= 1'b0;
            bus.overrun <= 1'b0;
        end else begin
            if (accept) sum <= sum_nxt;
            if (accept && bus.fill_count != DEPTH) bus.fill_count <= bus.fill_count + 1'b1;
            if (load) bus.avg_out <= DATA_W'(sum_nxt >> LOG2_DEPTH);
            bus.avg_valid <= load || (bus.avg_valid && !bus.avg_ready);
            if (load && bus.avg_valid && !bus.avg_ready) bus.overrun <= 1'b1;
        end
`ifdef ADC_AVG_PEAK_EN
    always_ff @(posedge SCLK or negedge reset)
        if (!reset) bus.peak_out <= '0;
        else if (bus.clear) bus.peak_out <= '0;
        else if (accept && bus.sample_in > bus.peak_out) bus.peak_out <= bus.sample_in;
`endif
endmodule

// File: doc/adc_moving_avg.md
ADC_MOVING_AVG -- requirements
Module: adc_moving_avg

Interface
REQ-001 SHALL have parameter DATA_W, default 12, sample width in bits.
REQ-002 SHALL have parameter LOG2_DEPTH, default 3, log2 of averaging window depth (8 samples).
REQ-003 SHALL have port SCLK  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sample_in  input  DATA_W  12-bit ADC sample from the serial receiver.
REQ-006 SHALL have port sample_valid  input  1  one-cycle strobe (receiver done tick) qualifying sample_in.
REQ-007 SHALL have port clear  input  1  synchronous flush of window, sum and flags.
REQ-008 SHALL have port avg_out  output  DATA_W  window average.
REQ-009 SHALL have port avg_valid  output  1  avg_out holds an unconsumed average.
REQ-010 SHALL have port avg_ready  input  1  consumer accepts avg_out when high with avg_valid.
REQ-011 SHALL have port fill_count  output  LOG2_DEPTH+1  samples in window, saturating at 2^LOG2_DEPTH.
REQ-012 SHALL have port overrun  output  1  sticky: an unconsumed average was overwritten.

Function
REQ-013 SHALL implement states EMPTY, FILL, FULL; EMPTY->FILL on first sample, FILL->FULL on the 2^LOG2_DEPTH-th sample, FULL stays FULL; clear from any state -> EMPTY.
REQ-014 SHALL store each accepted sample in a circular buffer; write pointer wraps modulo 2^LOG2_DEPTH.
REQ-015 SHALL keep running sum of width DATA_W+LOG2_DEPTH: sum += sample_in in EMPTY/FILL; sum += sample_in - oldest in FULL; never overflows.
REQ-016 SHALL compute avg_out = sum >> LOG2_DEPTH (truncation), registered one cycle after the sample that completes or updates a full window.
REQ-017 SHALL assert avg_valid only from FULL; no average produced during EMPTY/FILL.
REQ-018 SHALL hold avg_out/avg_valid stable until a rising edge with avg_valid & avg_ready, then deassert avg_valid unless a new average is loaded that same edge.
REQ-019 SHALL, when a new average is loaded while avg_valid=1 and avg_ready=0, overwrite avg_out and set overrun.
REQ-020 SHALL, on simultaneous consume and new average, treat the old value as consumed, load the new one, keep avg_valid=1, not set overrun.
REQ-021 SHALL give clear priority over sample_valid in the same cycle; the sample is dropped.
REQ-022 SHALL ignore sample_in when sample_valid=0.

Reset
REQ-023 SHALL on reset low: state EMPTY, pointer 0, sum 0, fill_count 0, avg_out 0, avg_valid 0, overrun 0; buffer contents need not be cleared.
REQ-024 SHALL on clear apply the same values as REQ-023 on the next rising edge.
REQ-025 SHALL abandon any partial window on reset mid-operation; the next window restarts from EMPTY.

Configuration
REQ-026 SHALL, with macro ADC_AVG_PEAK_EN defined, add output peak_out (DATA_W) = maximum sample_in accepted since reset/clear, updated the cycle after acceptance, reset value 0.
REQ-027 SHALL, without ADC_AVG_PEAK_EN, have no peak_out port and no peak logic.

Structure
REQ-028 SHALL place DATA_W and LOG2_DEPTH defaults and the state encoding (EMPTY, FILL, FULL) in shared package adc_pkg.
REQ-029 SHALL implement the circular sample store as sub-module adc_avg_ring (write port, read-oldest port, pointer wrap).

Verification
REQ-030 SHALL verify: reset, eight samples 0x100 -> fill_count 1..8, avg_valid rises one cycle after 8th, avg_out=0x100.
REQ-031 SHALL verify: then sample 0x900 with avg_ready=1 -> avg_out=0x200 (sum 0x1000), overrun stays 0.
REQ-032 SHALL verify: avg_ready=0, two further samples -> overrun=1, avg_out shows latest average; clear -> overrun 0, state EMPTY.
REQ-033 SHALL verify: clear and sample_valid same cycle after 5 samples -> fill_count 0, sample dropped, avg_valid 0.
REQ-034 SHALL verify: reset low mid-FILL (4 samples) -> all outputs 0 asynchronously; eight 0xFFF samples afterwards -> avg_out=0xFFF, no sum overflow.
REQ-035 SHALL verify with ADC_AVG_PEAK_EN: samples 0x123, 0xABC, 0x456 -> peak_out=0xABC; after clear peak_out=0.
